hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard and stall/forward unit for the five-stage MIPS pipeline.
- Consumes the D-stage decode outputs (rs/rt, Tuse, A3, RegWrite, Tnew, MDU class) and keeps a DEPTH-entry shift record of in-flight writers with self-decrementing Tnew.
- Adds a multiply/divide busy counter with configurable latencies.
- Drives the global stall and the D-stage forward selects. This replaces fixed per-stage E/M/W Tnew wiring.

Parameters:
- DEPTH, 3, number of post-D stages tracked (1=E ... DEPTH=W).
- TW, 3, width of Tuse/Tnew fields.
- SELW, 2, forward-select width; must satisfy 2**SELW > DEPTH.
- MUL_LAT, 5, cycles the MDU is busy after mult/multu enters E.
- DIV_LAT, 10, cycles the MDU is busy after div/divu enters E.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-low reset; reset==0 at a rising edge clears all state.
- d_valid, input, 1, D stage holds a real instruction.
- d_rs, input, 5, D source register rs.
- d_rt, input, 5, D source register rt.
- d_tuse_rs, input, TW, Tuse of rs; value 4 means not used.
- d_tuse_rt, input, TW, Tuse of rt; value 4 means not used.
- d_regwrite, input, 1, D instruction writes the GRF.
- d_a3, input, 5, D destination register.
- d_tnew, input, TW, Tnew the instruction will have on entering E.
- d_md_start, input, 1, D instruction is mult/multu/div/divu.
- d_md_is_div, input, 1, qualifies d_md_start as div/divu.
- d_is_mdft, input, 1, D instruction uses the MDU (md/mf/mt).
- flush, input, 1, kill the E-stage entry being loaded this cycle.
- stall, output, 1, freeze F/D and insert a bubble into E.
- fwd_rs_sel, output, SELW, 0 = GRF value, k = forward from stage k.
- fwd_rt_sel, output, SELW, 0 = GRF value, k = forward from stage k.
- md_busy, output, 1, MDU busy counter is nonzero.

Behaviour:
- State per stage k (1..DEPTH): vld[k], a3[k], tnew[k]. Plus md_cnt, an up-to-DIV_LAT counter.
- Reset (reset==0 at an edge): all vld=0, a3=0, tnew=0, md_cnt=0. Reset takes priority over every other input, including mid-stall and while md_cnt>0.
- Outputs after reset, with D idle: stall=0, fwd_rs_sel=0, fwd_rt_sel=0, md_busy=0.
- Entry into stage 1 each edge:
  - If d_valid && !stall && !flush: vld=d_regwrite && (d_a3!=0), a3=d_a3, tnew=d_tnew.
  - Otherwise a bubble: vld=0, tnew=0.
- Advance: stages 2..DEPTH always take stage k-1 (no back-pressure past E). tnew_next = (tnew==0) ? 0 : tnew-1. Stage DEPTH retires at the next edge.
- Match for rs: vld[k] && a3[k]==d_rs && d_rs!=0. Only the smallest matching k (the youngest writer) is considered; rt is identical.
- Stall (combinational):
  - stall = d_valid && (rs_hazard || rt_hazard || md_hazard).
  - rs_hazard: the youngest match has tnew[k] > d_tuse_rs.
  - md_hazard: d_is_mdft && md_cnt!=0.
- Forward select (combinational): fwd_*_sel = k if the youngest match has tnew[k]==0, else 0. If that match is still pending but tnew <= Tuse, fwd=0 here; downstream stages re-resolve it.
- MDU counter:
  - When d_md_start enters E (d_valid && !stall && !flush): md_cnt loads DIV_LAT if d_md_is_div, else MUL_LAT.
  - Otherwise md_cnt decrements if nonzero.
  - A load while md_cnt>0 is impossible, because md_hazard blocks it.
- md_busy = (md_cnt != 0).
- Simultaneous stall and flush: a bubble enters E and D is held.
- All comparisons are unsigned. No counter wraps past 0.

Test Plan:
- lw $2 (d_tnew=2) followed by add $3,$2,$2 (tuse 1/1) -> stall=1 for exactly 1 cycle. Next cycle the match is in stage 2 with tnew=1, so stall=0 and fwd_rs_sel=fwd_rt_sel=0.
- ori $1 (d_tnew=1) followed by beq $1,$0 (tuse_rs=0) -> stall 1 cycle. Then fwd_rs_sel=2 (stage M, tnew=0) and fwd_rt_sel=0 (rt=$0).
- addu writing $0 followed by a reader of $0 with tuse 0 -> stall=0 and fwd=0 throughout.
- addi $5 then ori $5 (both tnew 1), with an unrelated instruction in between, then a beq reading $5 -> the youngest entry (stage 1, ori, tnew 1) causes 1 stall cycle. The next cycle fwd_rs_sel=2 selects ori, not addi.
- mult (MUL_LAT=5) followed by mflo -> md_busy=1 and stall=1 for 5 cycles; mflo issues on the 6th. With div (DIV_LAT=10), stall lasts 10 cycles.
- reset=0 asserted during the div busy window -> after that edge md_cnt=0, all vld=0, stall=0, md_busy=0. Normal issue resumes on the first edge with reset=1.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight GRF writers with self-decrementing Tnew,
// resolves D-stage stall and forward selects, and models MDU busy time.
module hazard_scoreboard #(
    parameter int DEPTH   = 3,
    parameter int TW      = 3,
    parameter int SELW    = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            d_valid,
    input  logic [4:0]      d_rs,
    input  logic [4:0]      d_rt,
    input  logic [TW-1:0]   d_tuse_rs,
    input  logic [TW-1:0]   d_tuse_rt,
    input  logic            d_regwrite,
    input  logic [4:0]      d_a3,
    input  logic [TW-1:0]   d_tnew,
    input  logic            d_md_start,
    input  logic            d_md_is_div,
    input  logic            d_is_mdft,
    input  logic            flush,
    output logic            stall,
    output logic [SELW-1:0] fwd_rs_sel,
    output logic [SELW-1:0] fwd_rt_sel,
    output logic            md_busy
);
    localparam int CW = $clog2(DIV_LAT + 1);

    logic [DEPTH:1]  vld;
    logic [4:0]      a3   [1:DEPTH];
    logic [TW-1:0]   tnew [1:DEPTH];
    logic [CW-1:0]   md_cnt;

    logic            rs_hit, rt_hit;
    logic [TW-1:0]   rs_tnew, rt_tnew;
    logic [SELW-1:0] rs_k, rt_k;
    logic            rs_hazard, rt_hazard, md_hazard;
    logic            issue;

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        rs_tnew = '0;
        rt_tnew = '0;
        rs_k    = '0;
        rt_k    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (vld[k] && a3[k] == d_rs && d_rs != 5'd0) begin
                rs_hit  = 1'b1;
                rs_tnew = tnew[k];
                rs_k    = SELW'(k);
            end
            if (vld[k] && a3[k] == d_rt && d_rt != 5'd0) begin
                rt_hit  = 1'b1;
                rt_tnew = tnew[k];
                rt_k    = SELW'(k);
            end
        end
    end

    assign rs_hazard  = rs_hit && (rs_tnew > d_tuse_rs);
    assign rt_hazard  = rt_hit && (rt_tnew > d_tuse_rt);
    assign md_hazard  = d_is_mdft && (md_cnt != '0);
    assign stall      = d_valid && (rs_hazard || rt_hazard || md_hazard);
    assign fwd_rs_sel = (rs_hit && rs_tnew == '0) ? rs_k : '0;
    assign fwd_rt_sel = (rt_hit && rt_tnew == '0) ? rt_k : '0;
    assign md_busy    = (md_cnt != '0);
    assign issue      = d_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld    <= '0;
            md_cnt <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                a3[k]   <= '0;
                tnew[k] <= '0;
            end
        end else begin
            vld[1]  <= issue && d_regwrite && (d_a3 != 5'd0);
            a3[1]   <= issue ? d_a3 : 5'd0;
            tnew[1] <= issue ? d_tnew : '0;
            for (int k = 2; k <= DEPTH; k++) begin
                vld[k]  <= vld[k-1];
                a3[k]   <= a3[k-1];
                tnew[k] <= (tnew[k-1] == '0) ? '0 : tnew[k-1] - 1'b1;
            end
            if (issue && d_md_start)
                md_cnt <= d_md_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus
// randomized instruction streams against a writer-list reference model.
module tb_hazard_scoreboard;
    localparam int DEPTH   = 3;
    localparam int TW      = 3;
    localparam int SELW    = 2;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            d_valid;
    logic [4:0]      d_rs, d_rt, d_a3;
    logic [TW-1:0]   d_tuse_rs, d_tuse_rt, d_tnew;
    logic            d_regwrite, d_md_start, d_md_is_div, d_is_mdft;
    logic            flush;
    logic            stall, md_busy;
    logic [SELW-1:0] fwd_rs_sel, fwd_rt_sel;

    hazard_scoreboard #(
        .DEPTH(DEPTH), .TW(TW), .SELW(SELW),
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_regwrite(d_regwrite), .d_a3(d_a3), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_is_div(d_md_is_div),
        .d_is_mdft(d_is_mdft), .flush(flush),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
    );

    typedef struct {
        bit v; bit [4:0] rs; bit [4:0] rt; int urs; int urt;
        bit rw; bit [4:0] a3; int tn; bit ms; bit mdiv; bit mf;
    } ins_t;

    // Each issued writer remembers the cycle it entered E.
    typedef struct { bit [4:0] a3; int tn; int e; } wr_t;

    wr_t wq[$];
    int  cyc      = 0;
    int  md_until = 0;
    int  n_cmp    = 0;
    int  n_bad    = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    function automatic void look(input bit [4:0] r, output bit hit,
                                 output int tn, output int st);
        hit = 0; tn = 0; st = 0;
        if (r == 5'd0) return;
        foreach (wq[i]) begin
            int s;
            int left;
            s    = cyc - wq[i].e + 1;
            left = wq[i].tn - (s - 1);
            if (wq[i].a3 == r && s >= 1 && s <= DEPTH && (!hit || s < st)) begin
                hit = 1;
                st  = s;
                tn  = (left > 0) ? left : 0;
            end
        end
    endfunction

    function automatic ins_t mk(input bit [4:0] rs, input bit [4:0] rt,
                                input int urs, input int urt, input bit rw,
                                input bit [4:0] a3, input int tn);
        ins_t c;
        c.v = 1; c.rs = rs; c.rt = rt; c.urs = urs; c.urt = urt;
        c.rw = rw; c.a3 = a3; c.tn = tn;
        c.ms = 0; c.mdiv = 0; c.mf = 0;
        return c;
    endfunction

    function automatic ins_t nop();
        ins_t c;
        c = mk(0, 0, 4, 4, 0, 0, 0);
        c.v = 0;
        return c;
    endfunction

    function automatic ins_t md(input bit start, input bit dv);
        ins_t c;
        c = mk(0, 0, 4, 4, 0, 0, 0);
        c.ms = start; c.mdiv = dv; c.mf = 1;
        if (!start) begin c.rw = 1; c.a3 = 5'd8; c.tn = 1; end
        return c;
    endfunction

    function automatic ins_t rnd();
        ins_t c;
        c = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom_range(0, 4), $urandom_range(0, 4),
               ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 3)),
               $urandom_range(0, 3));
        c.v    = ($urandom_range(0, 19) != 0);
        c.ms   = ($urandom_range(0, 19) == 0);
        c.mdiv = $urandom_range(0, 1);
        c.mf   = c.ms || ($urandom_range(0, 9) == 0);
        return c;
    endfunction

    task automatic run_cycle(input ins_t c, input bit rst, input bit fl,
                             output bit iss);
        bit hs, ht, es;
        int ts, tt, ss, st;
        @(negedge clk);
        reset       = !rst;
        d_valid     = c.v;
        d_rs        = c.rs;
        d_rt        = c.rt;
        d_tuse_rs   = TW'(c.urs);
        d_tuse_rt   = TW'(c.urt);
        d_regwrite  = c.rw;
        d_a3        = c.a3;
        d_tnew      = TW'(c.tn);
        d_md_start  = c.ms;
        d_md_is_div = c.mdiv;
        d_is_mdft   = c.mf;
        flush       = fl;
        #1;
        look(c.rs, hs, ts, ss);
        look(c.rt, ht, tt, st);
        es = c.v && ((hs && ts > c.urs) || (ht && tt > c.urt)
                     || (c.mf && cyc < md_until));
        chk("stall", 32'(stall), 32'(es));
        chk("fwd_rs", 32'(fwd_rs_sel), (hs && ts == 0) ? ss : 0);
        chk("fwd_rt", 32'(fwd_rt_sel), (ht && tt == 0) ? st : 0);
        chk("md_busy", 32'(md_busy), 32'(cyc < md_until));
        @(posedge clk);
        iss = !rst && c.v && !es && !fl;
        cyc++;
        if (rst) begin
            wq.delete();
            md_until = 0;
        end else begin
            if (iss && c.rw && c.a3 != 5'd0)
                wq.push_back('{a3: c.a3, tn: c.tn, e: cyc});
            if (iss && c.ms)
                md_until = cyc + (c.mdiv ? DIV_LAT : MUL_LAT);
        end
        while (wq.size() > 0 && cyc - wq[0].e + 1 > DEPTH)
            void'(wq.pop_front());
    endtask

    task automatic issue(input ins_t c, input string tag);
        bit iss;
        int n;
        n = 0;
        do begin
            run_cycle(c, 0, 0, iss);
            n++;
        end while (!iss && n < 40);
        chk(tag, 32'(iss), 32'd1);
    endtask

    task automatic idle(input int n);
        bit iss;
        for (int i = 0; i < n; i++) run_cycle(nop(), 0, 0, iss);
    endtask

    initial begin
        bit   iss;
        ins_t cur;
        int   stalls;
        reset = 0; d_valid = 0; d_rs = 0; d_rt = 0; d_a3 = 0;
        d_tuse_rs = 0; d_tuse_rt = 0; d_tnew = 0; d_regwrite = 0;
        d_md_start = 0; d_md_is_div = 0; d_is_mdft = 0; flush = 0;

        run_cycle(nop(), 1, 0, iss);
        run_cycle(nop(), 1, 0, iss);
        idle(2);

        // lw $2 ; add $3,$2,$2
        issue(mk(0, 0, 4, 4, 1, 2, 2), "lw");
        issue(mk(2, 2, 1, 1, 1, 3, 1), "add");
        idle(4);
        // ori $1 ; beq $1,$0
        issue(mk(0, 0, 4, 4, 1, 1, 1), "ori");
        issue(mk(1, 0, 0, 0, 0, 0, 0), "beq");
        idle(4);
        // write to $0 then read $0
        issue(mk(0, 0, 4, 4, 1, 0, 1), "addu0");
        issue(mk(0, 0, 0, 0, 0, 0, 0), "rd0");
        idle(4);
        // addi $5 ; nop ; ori $5 ; beq $5
        issue(mk(0, 0, 4, 4, 1, 5, 1), "addi");
        issue(mk(0, 0, 4, 4, 0, 0, 0), "mid");
        issue(mk(0, 0, 4, 4, 1, 5, 1), "ori5");
        issue(mk(5, 0, 0, 0, 0, 0, 0), "beq5");
        idle(4);

        // mult then mflo: count stall cycles seen by the bench
        issue(md(1, 0), "mult");
        stalls = 0;
        do begin
            run_cycle(md(0, 0), 0, 0, iss);
            if (!iss) stalls++;
        end while (!iss && stalls < 40);
        chk("mult_stalls", 32'(stalls), 32'(MUL_LAT));
        idle(2);
        issue(md(1, 1), "div");
        stalls = 0;
        do begin
            run_cycle(md(0, 0), 0, 0, iss);
            if (!iss) stalls++;
        end while (!iss && stalls < 40);
        chk("div_stalls", 32'(stalls), 32'(DIV_LAT));
        idle(2);

        // reset in the middle of a div busy window
        issue(md(1, 1), "div2");
        for (int i = 0; i < 3; i++) run_cycle(md(0, 0), 0, 0, iss);
        run_cycle(md(0, 0), 1, 0, iss);
        run_cycle(md(0, 0), 0, 0, iss);
        chk("post_reset_issue", 32'(iss), 32'd1);
        idle(3);

        // stall and flush together
        issue(mk(0, 0, 4, 4, 1, 6, 3), "lw6");
        run_cycle(mk(6, 0, 0, 4, 1, 7, 1), 0, 1, iss);
        idle(3);

        cur = rnd();
        for (int i = 0; i < 3000; i++) begin
            bit rst, fl;
            rst = ($urandom_range(0, 99) == 0);
            fl  = ($urandom_range(0, 99) < 8);
            run_cycle(cur, rst, fl, iss);
            if (iss || !cur.v || $urandom_range(0, 9) == 0) cur = rnd();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
